// File: rtl/touch_ui_decoder.sv
// Touch panel decoder: debounces pen samples, classifies presses into grid cells or a
// slider with minus/plus buttons, and maintains a saturating slider value with drag and auto-repeat.
module touch_ui_decoder #(
    parameter int COORD_W     = 8,
    parameter int VAL_W       = 7,
    parameter int GRID_X0     = 7,
    parameter int GRID_Y0     = 7,
    parameter int CELL_W      = 19,
    parameter int CELL_H      = 8,
    parameter int GRID_COLS   = 12,
    parameter int GRID_ROWS   = 16,
    parameter int BAR_X0      = 40,
    parameter int BAR_X1      = 220,
    parameter int BAR_Y0      = 155,
    parameter int BAR_Y1      = 168,
    parameter int BTN_W       = 20,
    parameter int DEBOUNCE    = 3,
    parameter int JITTER      = 2,
    parameter int REPEAT_DLY  = 16,
    parameter int REPEAT_RATE = 4
) (
    input  logic               sys_clk,
    input  logic               iRST,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               coord_valid,
    input  logic               pen_down,
    input  logic               val_load,
    input  logic [VAL_W-1:0]   val_in,
    output logic               cell_hit,
    output logic [3:0]         cell_col,
    output logic [3:0]         cell_row,
    output logic [VAL_W-1:0]   val_out,
    output logic               val_wr,
    output logic [COORD_W-1:0] hit_x,
    output logic [COORD_W-1:0] hit_y,
    output logic               released
);
    localparam int PW      = COORD_W + VAL_W;
    localparam int VAL_MAX = (1 << VAL_W) - 1;
    localparam int DW      = $clog2(DEBOUNCE + 1);
    localparam int RDW     = $clog2(REPEAT_DLY + 1);
    localparam int RRW     = $clog2(REPEAT_RATE + 1);

    localparam logic [VAL_W-1:0]   VMAX = VAL_W'(VAL_MAX);
    localparam logic [COORD_W-1:0] GX0  = COORD_W'(GRID_X0);
    localparam logic [COORD_W-1:0] GY0  = COORD_W'(GRID_Y0);
    localparam logic [COORD_W-1:0] CWD  = COORD_W'(CELL_W);
    localparam logic [COORD_W-1:0] CHD  = COORD_W'(CELL_H);
    localparam logic [COORD_W-1:0] NCOL = COORD_W'(GRID_COLS);
    localparam logic [COORD_W-1:0] NROW = COORD_W'(GRID_ROWS);
    localparam logic [COORD_W-1:0] BX0  = COORD_W'(BAR_X0);
    localparam logic [COORD_W-1:0] BX1  = COORD_W'(BAR_X1);
    localparam logic [COORD_W-1:0] BY0  = COORD_W'(BAR_Y0);
    localparam logic [COORD_W-1:0] BY1  = COORD_W'(BAR_Y1);
    localparam logic [COORD_W-1:0] MX0  = COORD_W'(BAR_X0 - BTN_W);
    localparam logic [COORD_W-1:0] PX1  = COORD_W'(BAR_X1 + BTN_W);
    localparam logic [COORD_W-1:0] JIT  = COORD_W'(JITTER);
    localparam logic [DW-1:0]      DEB1 = DW'(DEBOUNCE - 1);
    localparam logic [RDW-1:0]     RDLY = RDW'(REPEAT_DLY);
    localparam logic [RDW-1:0]     RDL1 = RDW'(REPEAT_DLY - 1);
    localparam logic [RRW-1:0]     RRT1 = RRW'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {S_IDLE, S_DEBOUNCE, S_PRESS, S_HOLD, S_RELEASE} state_t;
    typedef enum logic [2:0] {R_NONE, R_GRID, R_BAR, R_MINUS, R_PLUS} region_t;

    state_t             state;
    region_t            region, hold_reg;
    logic [COORD_W-1:0] ref_x, ref_y, drag_x;
    logic [DW-1:0]      cnt;
    logic [RDW-1:0]     rpt_cnt;
    logic [RRW-1:0]     rate_cnt;
    logic               pend_drag, pend_step;
    logic [COORD_W-1:0] gx, gy, col_q, row_q;
    logic               upd;
    logic [VAL_W-1:0]   upd_val;

    function automatic logic in_bar_row(input logic [COORD_W-1:0] yy);
        return (yy >= BY0) && (yy <= BY1);
    endfunction

    function automatic logic near(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
        logic [COORD_W-1:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return d <= JIT;
    endfunction

    // Clamp to the bar, then scale with a constant divisor; the product width holds the full range.
    function automatic logic [VAL_W-1:0] bar_map(input logic [COORD_W-1:0] xx);
        logic [COORD_W-1:0] xc;
        logic [PW-1:0]      prod, q;
        xc   = (xx < BX0) ? BX0 : ((xx > BX1) ? BX1 : xx);
        prod = PW'(xc - BX0) * PW'(VAL_MAX);
        q    = prod / PW'(BAR_X1 - BAR_X0);
        return (q > PW'(VAL_MAX)) ? VMAX : VAL_W'(q);
    endfunction

    always_comb begin
        gx     = hit_x - GX0;
        gy     = hit_y - GY0;
        col_q  = gx / CWD;
        row_q  = gy / CHD;
        region = R_NONE;
        if (hit_x >= GX0 && hit_y >= GY0 && col_q < NCOL && row_q < NROW)
            region = R_GRID;
        else if (in_bar_row(hit_y)) begin
            if (hit_x >= BX0 && hit_x <= BX1)      region = R_BAR;
            else if (hit_x >= MX0 && hit_x < BX0)  region = R_MINUS;
            else if (hit_x > BX1 && hit_x <= PX1)  region = R_PLUS;
        end
    end

    // Slider update candidate: press action, or a drag/repeat event captured on the previous cycle.
    always_comb begin
        upd     = 1'b0;
        upd_val = val_out;
        if (state == S_PRESS) begin
            case (region)
                R_BAR:   begin upd_val = bar_map(hit_x); upd = 1'b1; end
                R_MINUS: if (val_out != '0)  begin upd_val = val_out - VAL_W'(1); upd = 1'b1; end
                R_PLUS:  if (val_out != VMAX) begin upd_val = val_out + VAL_W'(1); upd = 1'b1; end
                default: ;
            endcase
        end else if (pend_drag) begin
            upd_val = bar_map(drag_x);
            upd     = (upd_val != val_out);
        end else if (pend_step) begin
            if (hold_reg == R_MINUS && val_out != '0) begin
                upd_val = val_out - VAL_W'(1);
                upd     = 1'b1;
            end else if (hold_reg == R_PLUS && val_out != VMAX) begin
                upd_val = val_out + VAL_W'(1);
                upd     = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (iRST) begin
            state     <= S_IDLE;
            hold_reg  <= R_NONE;
            ref_x     <= '0;
            ref_y     <= '0;
            drag_x    <= '0;
            cnt       <= '0;
            rpt_cnt   <= '0;
            rate_cnt  <= '0;
            pend_drag <= 1'b0;
            pend_step <= 1'b0;
            cell_hit  <= 1'b0;
            cell_col  <= '0;
            cell_row  <= '0;
            val_out   <= '0;
            val_wr    <= 1'b0;
            hit_x     <= '0;
            hit_y     <= '0;
            released  <= 1'b0;
        end else begin
            cell_hit  <= 1'b0;
            val_wr    <= 1'b0;
            released  <= 1'b0;
            pend_drag <= 1'b0;
            pend_step <= 1'b0;

            if (val_load) val_out <= val_in;
            else if (upd) begin
                val_out <= upd_val;
                val_wr  <= 1'b1;
            end

            case (state)
                S_IDLE: if (coord_valid && pen_down) begin
                    ref_x <= x;
                    ref_y <= y;
                    cnt   <= DW'(1);
                    state <= S_DEBOUNCE;
                end
                S_DEBOUNCE: begin
                    if (!pen_down) state <= S_IDLE;
                    else if (coord_valid) begin
                        if (near(x, ref_x) && near(y, ref_y)) begin
                            if (cnt == DEB1) begin
                                hit_x <= x;
                                hit_y <= y;
                                cnt   <= '0;
                                state <= S_PRESS;
                            end else cnt <= cnt + DW'(1);
                        end else begin
                            ref_x <= x;
                            ref_y <= y;
                            cnt   <= DW'(1);
                        end
                    end
                end
                S_PRESS: begin
                    hold_reg <= region;
                    rpt_cnt  <= '0;
                    rate_cnt <= '0;
                    if (region == R_GRID) begin
                        cell_col <= 4'(col_q);
                        cell_row <= 4'(row_q);
                        cell_hit <= 1'b1;
                    end
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!pen_down) state <= S_RELEASE;
                    else if (coord_valid) begin
                        if (hold_reg == R_BAR && in_bar_row(y)) begin
                            drag_x    <= x;
                            pend_drag <= 1'b1;
                        end else if (hold_reg == R_MINUS || hold_reg == R_PLUS) begin
                            // Initial delay phase, then a free-running rate phase.
                            if (rpt_cnt != RDLY) begin
                                rpt_cnt <= rpt_cnt + RDW'(1);
                                if (rpt_cnt == RDL1) pend_step <= 1'b1;
                            end else if (rate_cnt == RRT1) begin
                                rate_cnt  <= '0;
                                pend_step <= 1'b1;
                            end else rate_cnt <= rate_cnt + RRW'(1);
                        end
                    end
                end
                S_RELEASE: begin
                    released <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_touch_ui_decoder.sv
// Bench for touch_ui_decoder: directed scenarios plus random gestures checked against a
// gesture-level model of classification, slider mapping and repeat stepping.
module tb_touch_ui_decoder;
    logic       sys_clk = 1'b0;
    logic       iRST = 1'b1;
    logic [7:0] x = '0, y = '0;
    logic       coord_valid = 1'b0, pen_down = 1'b0, val_load = 1'b0;
    logic [6:0] val_in = '0;
    logic       cell_hit, val_wr, released;
    logic [3:0] cell_col, cell_row;
    logic [6:0] val_out;
    logic [7:0] hit_x, hit_y;

    int errors = 0, checks = 0;
    int n_hit = 0, n_wr = 0, n_rel = 0;

    touch_ui_decoder dut (
        .sys_clk(sys_clk), .iRST(iRST), .x(x), .y(y), .coord_valid(coord_valid),
        .pen_down(pen_down), .val_load(val_load), .val_in(val_in),
        .cell_hit(cell_hit), .cell_col(cell_col), .cell_row(cell_row),
        .val_out(val_out), .val_wr(val_wr), .hit_x(hit_x), .hit_y(hit_y),
        .released(released)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (cell_hit) n_hit++;
        if (val_wr)   n_wr++;
        if (released) n_rel++;
    end

    // ---------------- reference model ----------------
    localparam int R_NONE = 0, R_GRID = 1, R_BAR = 2, R_MINUS = 3, R_PLUS = 4;

    function automatic int mregion(input int px, input int py, output int col, output int row);
        col = 0; row = 0;
        if (px >= 7 && py >= 7 && (px - 7) / 19 < 12 && (py - 7) / 8 < 16) begin
            col = (px - 7) / 19;
            row = (py - 7) / 8;
            return R_GRID;
        end
        if (py < 155 || py > 168) return R_NONE;
        if (px >= 40 && px <= 220) return R_BAR;
        if (px >= 20 && px <= 39)  return R_MINUS;
        if (px >= 221 && px <= 240) return R_PLUS;
        return R_NONE;
    endfunction

    function automatic int mmap(input int px);
        int v, c;
        c = (px < 40) ? 40 : ((px > 220) ? 220 : px);
        v = ((c - 40) * 127) / 180;
        return (v > 127) ? 127 : v;
    endfunction

    function automatic bit is_step(input int k);
        return (k == 16) || (k > 16 && ((k - 16) % 4) == 0);
    endfunction

    // Press plus hold-step sequence for a button; returns final value and counts writes.
    function automatic int mbutton(input int start, input int holds, input bit plus, output int wr);
        int v = start;
        wr = 0;
        for (int k = 0; k <= holds; k++) begin
            if (k == 0 || is_step(k)) begin
                if (plus && v < 127)       begin v++; wr++; end
                else if (!plus && v > 0)   begin v--; wr++; end
            end
        end
        return v;
    endfunction

    function automatic int clip(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(negedge sys_clk); #1;
    endtask

    task automatic sample(input int sx, input int sy);
        x = 8'(sx); y = 8'(sy); coord_valid = 1'b1;
        tick();
        coord_valid = 1'b0;
        tick();
    endtask

    task automatic press(input int sx, input int sy);
        pen_down = 1'b1;
        repeat (3) sample(sx, sy);
    endtask

    task automatic lift();
        pen_down = 1'b0;
        repeat (4) tick();
    endtask

    task automatic do_load(input int v);
        val_in = 7'(v); val_load = 1'b1;
        tick();
        val_load = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        iRST = 1'b1;
        repeat (3) tick();
        iRST = 1'b0;
        tick();
        checks++; if (val_out !== 7'd0) begin errors++; $display("FAIL reset_val: got %0d want 0", val_out); end
        checks++; if ({cell_col, cell_row} !== 8'd0) begin errors++; $display("FAIL reset_cell: got %0d/%0d want 0/0", cell_col, cell_row); end
        checks++; if ({hit_x, hit_y} !== 16'd0) begin errors++; $display("FAIL reset_hit: got %0d/%0d want 0/0", hit_x, hit_y); end
        checks++; if ({cell_hit, val_wr, released} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {cell_hit, val_wr, released}); end
    endtask

    task automatic test_grid_press();
        int col, row, reg_e, h0, w0, r0;
        reg_e = mregion(45, 30, col, row);
        h0 = n_hit; w0 = n_wr; r0 = n_rel;
        pen_down = 1'b1;
        sample(45, 30);
        sample(45, 30);
        x = 8'd45; y = 8'd30; coord_valid = 1'b1;
        tick();
        coord_valid = 1'b0;
        checks++; if (cell_hit !== 1'b0) begin errors++; $display("FAIL grid_hit_early: got %b want 0 at N+1", cell_hit); end
        tick();
        checks++; if (cell_hit !== (reg_e == R_GRID)) begin errors++; $display("FAIL grid_hit_n2: got %b want 1 at N+2", cell_hit); end
        checks++; if (cell_col !== 4'(col) || cell_row !== 4'(row)) begin errors++; $display("FAIL grid_cell: got %0d/%0d want %0d/%0d", cell_col, cell_row, col, row); end
        checks++; if (hit_x !== 8'd45 || hit_y !== 8'd30) begin errors++; $display("FAIL grid_hitxy: got %0d/%0d want 45/30", hit_x, hit_y); end
        tick();
        pen_down = 1'b0;
        tick();
        checks++; if (released !== 1'b0) begin errors++; $display("FAIL rel_early: got %b want 0 at P+1", released); end
        tick();
        checks++; if (released !== 1'b1) begin errors++; $display("FAIL rel_p2: got %b want 1 at P+2", released); end
        repeat (3) tick();
        checks++; if (n_hit - h0 !== 1 || n_wr - w0 !== 0 || n_rel - r0 !== 1) begin
            errors++; $display("FAIL grid_counts: got hit=%0d wr=%0d rel=%0d want 1/0/1", n_hit - h0, n_wr - w0, n_rel - r0);
        end
    endtask

    task automatic test_jitter_bar();
        int w0, e;
        w0 = n_wr;
        pen_down = 1'b1;
        sample(130, 160);
        sample(134, 160);
        sample(134, 160);
        checks++; if (hit_x !== 8'd45) begin errors++; $display("FAIL jitter_early_accept: got hit_x %0d want 45", hit_x); end
        sample(134, 160);
        e = mmap(134);
        checks++; if (val_out !== 7'(e) || hit_x !== 8'd134) begin errors++; $display("FAIL bar_press: got %0d hx=%0d want %0d hx=134", val_out, hit_x, e); end
        checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL bar_press_wr: got %0d want 1", n_wr - w0); end
        sample(40, 160);
        checks++; if (val_out !== 7'(mmap(40))) begin errors++; $display("FAIL drag_low: got %0d want %0d", val_out, mmap(40)); end
        sample(220, 160);
        checks++; if (val_out !== 7'(mmap(220))) begin errors++; $display("FAIL drag_high: got %0d want %0d", val_out, mmap(220)); end
        sample(250, 160);
        checks++; if (val_out !== 7'(mmap(250))) begin errors++; $display("FAIL drag_clamp: got %0d want %0d", val_out, mmap(250)); end
        sample(100, 200);
        checks++; if (val_out !== 7'(mmap(250)) || n_wr - w0 !== 3) begin
            errors++; $display("FAIL drag_wr: got val=%0d wr=%0d want %0d/3", val_out, n_wr - w0, mmap(250));
        end
        lift();
    endtask

    task automatic test_plus_repeat();
        int w0, ev, ew;
        do_load(10);
        w0 = n_wr;
        press(230, 160);
        repeat (24) sample(230, 160);
        ev = mbutton(10, 24, 1'b1, ew);
        checks++; if (val_out !== 7'(ev) || n_wr - w0 !== ew) begin
            errors++; $display("FAIL plus_repeat: got val=%0d wr=%0d want %0d/%0d", val_out, n_wr - w0, ev, ew);
        end
        lift();
        do_load(126);
        w0 = n_wr;
        press(230, 160);
        repeat (24) sample(230, 160);
        ev = mbutton(126, 24, 1'b1, ew);
        checks++; if (val_out !== 7'(ev) || n_wr - w0 !== ew) begin
            errors++; $display("FAIL plus_saturate: got val=%0d wr=%0d want %0d/%0d", val_out, n_wr - w0, ev, ew);
        end
        lift();
        do_load(2);
        w0 = n_wr;
        press(30, 160);
        repeat (20) sample(30, 160);
        ev = mbutton(2, 20, 1'b0, ew);
        checks++; if (val_out !== 7'(ev) || n_wr - w0 !== ew) begin
            errors++; $display("FAIL minus_saturate: got val=%0d wr=%0d want %0d/%0d", val_out, n_wr - w0, ev, ew);
        end
        lift();
    endtask

    task automatic test_abort();
        int h0, w0, r0;
        logic [7:0] hx0;
        hx0 = hit_x; h0 = n_hit; w0 = n_wr; r0 = n_rel;
        pen_down = 1'b1;
        sample(100, 50);
        sample(100, 50);
        pen_down = 1'b0;
        repeat (3) tick();
        checks++; if (n_hit != h0 || n_wr != w0 || n_rel != r0 || hit_x !== hx0) begin
            errors++; $display("FAIL abort_quiet: got hit=%0d wr=%0d rel=%0d hx=%0d want 0/0/0 hx=%0d", n_hit - h0, n_wr - w0, n_rel - r0, hit_x, hx0);
        end
        pen_down = 1'b1;
        sample(100, 50);
        sample(100, 50);
        checks++; if (n_hit - h0 !== 0) begin errors++; $display("FAIL abort_idle: got hit=%0d want 0 after 2 samples", n_hit - h0); end
        sample(100, 50);
        checks++; if (n_hit - h0 !== 1) begin errors++; $display("FAIL abort_repress: got hit=%0d want 1", n_hit - h0); end
        lift();
    endtask

    task automatic test_reset_hold();
        int r0;
        press(130, 160);
        iRST = 1'b1;
        tick();
        checks++; if ({val_out, hit_x, hit_y, cell_col, cell_row, cell_hit, val_wr, released} !== '0) begin
            errors++; $display("FAIL reset_hold: got val=%0d hx=%0d hy=%0d want all 0", val_out, hit_x, hit_y);
        end
        iRST = 1'b0;
        r0 = n_rel;
        lift();
        checks++; if (n_rel - r0 !== 0) begin errors++; $display("FAIL reset_hold_rel: got %0d want 0", n_rel - r0); end
    endtask

    task automatic test_load_priority();
        int w0;
        do_load(10);
        w0 = n_wr;
        press(230, 160);
        repeat (15) sample(230, 160);
        x = 8'd230; y = 8'd160; coord_valid = 1'b1;
        tick();
        coord_valid = 1'b0;
        val_in = 7'd50; val_load = 1'b1;
        tick();
        val_load = 1'b0;
        checks++; if (val_out !== 7'd50 || val_wr !== 1'b0) begin
            errors++; $display("FAIL load_prio: got val=%0d wr=%b want 50/0", val_out, val_wr);
        end
        tick();
        checks++; if (val_out !== 7'd50 || n_wr - w0 !== 1) begin
            errors++; $display("FAIL load_prio_after: got val=%0d wr=%0d want 50/1", val_out, n_wr - w0);
        end
        lift();
    endtask

    task automatic test_random();
        int mval, mcol, mrow, col, row, rg, k, bx, by, hx, hy, holds, h0, w0, r0, ewr, ehit, tmp, sx, sy;
        mval = int'(val_out); mcol = int'(cell_col); mrow = int'(cell_row);
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                mval = $urandom_range(0, 127);
                do_load(mval);
            end
            k = $urandom_range(0, 4);
            case (k)
                0: begin bx = 7 + $urandom_range(0, 227); by = 7 + $urandom_range(0, 127); end
                1: begin bx = $urandom_range(40, 220);    by = $urandom_range(155, 168); end
                2: begin bx = $urandom_range(20, 39);     by = $urandom_range(155, 168); end
                3: begin bx = $urandom_range(221, 240);   by = $urandom_range(155, 168); end
                default: begin bx = $urandom_range(245, 255); by = $urandom_range(0, 255); end
            endcase
            h0 = n_hit; w0 = n_wr; r0 = n_rel;
            pen_down = 1'b1;
            sample(bx, by);
            sample(clip(bx + $urandom_range(0, 2) - 1), clip(by + $urandom_range(0, 2) - 1));
            hx = clip(bx + $urandom_range(0, 2) - 1);
            hy = clip(by + $urandom_range(0, 2) - 1);
            sample(hx, hy);
            rg = mregion(hx, hy, col, row);
            ehit = 0; ewr = 0;
            holds = $urandom_range(0, 28);
            case (rg)
                R_GRID:  begin ehit = 1; mcol = col; mrow = row; end
                R_BAR:   begin mval = mmap(hx); ewr = 1; end
                R_MINUS: mval = mbutton(mval, holds, 1'b0, ewr);
                R_PLUS:  mval = mbutton(mval, holds, 1'b1, ewr);
                default: ;
            endcase
            for (int j = 0; j < holds; j++) begin
                sx = $urandom_range(0, 255);
                sy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(155, 168);
                sample(sx, sy);
                if (rg == R_BAR && sy >= 155 && sy <= 168) begin
                    tmp = mmap(sx);
                    if (tmp != mval) begin mval = tmp; ewr++; end
                end
            end
            lift();
            checks++; if (val_out !== 7'(mval)) begin errors++; $display("FAIL rnd%0d_val: got %0d want %0d", it, val_out, mval); end
            checks++; if (n_wr - w0 !== ewr) begin errors++; $display("FAIL rnd%0d_wr: got %0d want %0d", it, n_wr - w0, ewr); end
            checks++; if (n_hit - h0 !== ehit) begin errors++; $display("FAIL rnd%0d_hit: got %0d want %0d", it, n_hit - h0, ehit); end
            checks++; if (cell_col !== 4'(mcol) || cell_row !== 4'(mrow)) begin errors++; $display("FAIL rnd%0d_cell: got %0d/%0d want %0d/%0d", it, cell_col, cell_row, mcol, mrow); end
            checks++; if (hit_x !== 8'(hx) || hit_y !== 8'(hy)) begin errors++; $display("FAIL rnd%0d_hitxy: got %0d/%0d want %0d/%0d", it, hit_x, hit_y, hx, hy); end
            checks++; if (n_rel - r0 !== 1) begin errors++; $display("FAIL rnd%0d_rel: got %0d want 1", it, n_rel - r0); end
        end
    endtask

    initial begin
        test_reset();
        test_grid_press();
        test_jitter_bar();
        test_plus_repeat();
        test_abort();
        test_reset_hold();
        test_load_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
